// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pkg
//  Purpose  : Shared types, constants and helpers for the bit-serial
//             two's complementer (lane state type, word mode, clog2).
//  Revision : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // Per-lane serial negation state: pass bits through, or invert them
    typedef enum logic [0:0] {
        COPY   = 1'b0,
        INVERT = 1'b1
    } lane_state_t;

    // Word mode latched at the first bit of each word
    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_NEG  = 1'b1;

    // Ceiling log2, minimum 1 so a 2-bit word still gets a 1-bit counter
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tc_lane.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tc_lane
//  Purpose  : One serial lane: COPY/INVERT state, registered output bit and
//             most-negative-input overflow detection.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_tc_lane
    import serial_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    input  logic clr_i,
    input  logic first_i,
    input  logic last_i,
    input  logic mode_i,
    input  logic bit_i,
    output logic bit_o,
    output logic ovf_o
);

    lane_state_t state_q, state_d;
    lane_state_t w_cur;
    logic        bit_q, bit_d;
    logic        ovf_q, ovf_d;

    // Next-state, output bit and overflow for the bit presented this cycle
    always_comb begin
        // A word start forces COPY before bit 0 is processed
        w_cur   = first_i ? COPY : state_q;
        state_d = state_q;
        bit_d   = bit_q;
        ovf_d   = 1'b0;
        if (clr_i) begin
            state_d = COPY;
        end else if (valid_i) begin
            bit_d   = (w_cur == INVERT) ? ~bit_i : bit_i;
            // Still copying at the MSB with a 1 means the input was 100..0
            ovf_d   = (mode_i == MODE_NEG) && last_i && (w_cur == COPY) && bit_i;
            state_d = ((w_cur == COPY) && (mode_i == MODE_NEG) && bit_i) ? INVERT : w_cur;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= COPY;
            bit_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bit_o = bit_q;
    assign ovf_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/serial_twos_comp_n.sv
`default_nettype none
// ============================================================================
//  Module   : serial_twos_comp_n
//  Purpose  : Multi-lane, LSB-first bit-serial two's complementer with word
//             framing, per-word negate/pass mode, abort and overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_twos_comp_n
    import serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             i_valid,
    input  logic [LANES-1:0] i_bit,
    input  logic             i_neg,
    input  logic             i_clr,
    output logic             o_valid,
    output logic [LANES-1:0] o_bit,
    output logic             o_last,
    output logic [LANES-1:0] o_ovf
);

    localparam int               CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             valid_q;
    logic             last_q;
    logic             w_first;
    logic             w_lastbit;
    logic             w_mode;

    // Framing counter and word-mode latch; mode is taken live on bit 0
    always_comb begin
        w_first   = (cnt_q == '0);
        w_lastbit = (cnt_q == CNT_LAST);
        w_mode    = w_first ? i_neg : mode_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_valid) begin
            mode_d = w_mode;
            cnt_d  = w_lastbit ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Shared framing registers and output strobes
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            cnt_q   <= '0;
            mode_q  <= MODE_PASS;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            valid_q <= i_valid & ~i_clr;
            last_q  <= i_valid & ~i_clr & w_lastbit;
        end
    end

    assign o_valid = valid_q;
    assign o_last  = last_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        serial_tc_lane u_lane (
            .clk_i   (t_clk),
            .rst_i   (r),
            .valid_i (i_valid),
            .clr_i   (i_clr),
            .first_i (w_first),
            .last_i  (w_lastbit),
            .mode_i  (w_mode),
            .bit_i   (i_bit[k]),
            .bit_o   (o_bit[k]),
            .ovf_o   (o_ovf[k])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_twos_comp_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_twos_comp_n
//  Purpose  : Self-checking bench: 8-bit/2-lane and 4-bit/1-lane instances
//             compared against an arithmetic two's-complement model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_twos_comp_n;

    localparam int W  = 8;
    localparam int L  = 2;
    localparam int WB = 4;

    logic         t_clk = 1'b0;
    logic         r;
    logic         a_valid, a_neg, a_clr;
    logic [L-1:0] a_bit;
    logic         ao_valid, ao_last;
    logic [L-1:0] ao_bit, ao_ovf;
    logic         b_valid, b_neg, b_clr;
    logic [0:0]   b_bit;
    logic         bo_valid, bo_last;
    logic [0:0]   bo_bit, bo_ovf;

    int total = 0;
    int bad   = 0;

    always #5 t_clk = ~t_clk;

    serial_twos_comp_n #(.WIDTH(W), .LANES(L)) u_dut_a (
        .t_clk(t_clk), .r(r), .i_valid(a_valid), .i_bit(a_bit), .i_neg(a_neg),
        .i_clr(a_clr), .o_valid(ao_valid), .o_bit(ao_bit), .o_last(ao_last), .o_ovf(ao_ovf)
    );

    serial_twos_comp_n #(.WIDTH(WB), .LANES(1)) u_dut_b (
        .t_clk(t_clk), .r(r), .i_valid(b_valid), .i_bit(b_bit), .i_neg(b_neg),
        .i_clr(b_clr), .o_valid(bo_valid), .o_bit(bo_bit), .o_last(bo_last), .o_ovf(bo_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the value a word should come out as, by plain arithmetic
    function automatic logic [63:0] ref_word(input logic [63:0] x, input bit neg, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return neg ? ((64'd0 - x) & mask) : (x & mask);
    endfunction

    // Reference: negating the most-negative value overflows
    function automatic bit ref_ovf(input logic [63:0] x, input bit neg, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return neg && ((x & mask) == (64'd1 << (w - 1)));
    endfunction

    task automatic tick();
        @(posedge t_clk);
        #1;
    endtask

    // Send nbits of one word per lane on DUT A; optional gap and mid-word i_neg flip
    task automatic send_a(input logic [63:0] x0, input logic [63:0] x1, input bit neg,
                          input int nbits, input int gap_after, input int gap_len,
                          input int flip_at);
        logic [63:0] e0, e1;
        bit          v0, v1;
        e0 = ref_word(x0, neg, W);
        e1 = ref_word(x1, neg, W);
        v0 = ref_ovf(x0, neg, W);
        v1 = ref_ovf(x1, neg, W);
        for (int b = 0; b < nbits; b++) begin
            a_valid = 1'b1;
            a_clr   = 1'b0;
            a_bit   = {x1[b], x0[b]};
            a_neg   = (flip_at >= 0 && b >= flip_at) ? ~neg : neg;
            tick();
            chk("a_valid", 64'(ao_valid), 64'd1);
            chk("a_bit",   64'(ao_bit),   64'({e1[b], e0[b]}));
            chk("a_last",  64'(ao_last),  64'(b == W - 1));
            chk("a_ovf",   64'(ao_ovf),   (b == W - 1) ? 64'({v1, v0}) : 64'd0);
            if (b == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    a_valid = 1'b0;
                    a_bit   = 2'($urandom);
                    a_neg   = 1'($urandom);
                    tick();
                    chk("gap_valid", 64'(ao_valid), 64'd0);
                    chk("gap_bit",   64'(ao_bit),   64'({e1[b], e0[b]}));
                    chk("gap_last",  64'(ao_last),  64'd0);
                    chk("gap_ovf",   64'(ao_ovf),   64'd0);
                end
            end
        end
        a_valid = 1'b0;
    endtask

    // Send one full word on DUT B, no gaps
    task automatic send_b(input logic [63:0] x, input bit neg);
        logic [63:0] e;
        bit          v;
        e = ref_word(x, neg, WB);
        v = ref_ovf(x, neg, WB);
        for (int b = 0; b < WB; b++) begin
            b_valid = 1'b1;
            b_clr   = 1'b0;
            b_bit   = x[b];
            b_neg   = neg;
            tick();
            chk("b_valid", 64'(bo_valid), 64'd1);
            chk("b_bit",   64'(bo_bit),   64'(e[b]));
            chk("b_last",  64'(bo_last),  64'(b == WB - 1));
            chk("b_ovf",   64'(bo_ovf),   (b == WB - 1) ? 64'(v) : 64'd0);
        end
        b_valid = 1'b0;
    endtask

    initial begin
        r       = 1'b1;
        a_valid = 1'b0; a_neg = 1'b0; a_clr = 1'b0; a_bit = '0;
        b_valid = 1'b0; b_neg = 1'b0; b_clr = 1'b0; b_bit = '0;
        #2;
        chk("rst_valid", 64'(ao_valid), 64'd0);
        chk("rst_bit",   64'(ao_bit),   64'd0);
        chk("rst_last",  64'(ao_last),  64'd0);
        chk("rst_ovf",   64'(ao_ovf),   64'd0);
        chk("rst_b",     64'({bo_valid, bo_bit, bo_last, bo_ovf}), 64'd0);
        @(negedge t_clk);
        r = 1'b0;
        tick();

        // Directed: negate, most-negative, pass with mid-word flip, gaps
        send_a(64'h05, 64'h01, 1'b1, W, -1, 0, -1);
        send_a(64'h80, 64'h00, 1'b1, W, -1, 0, -1);
        send_a(64'h5A, 64'hA5, 1'b0, W, -1, 0, 3);
        send_a(64'h0C, 64'h80, 1'b1, W, 2, 3, -1);

        // Synchronous abort after 4 bits; the bit presented with i_clr is dropped
        send_a(64'($urandom), 64'($urandom), 1'b1, 4, -1, 0, -1);
        a_valid = 1'b1; a_clr = 1'b1; a_bit = 2'b11; a_neg = 1'b0;
        tick();
        chk("clr_valid", 64'(ao_valid), 64'd0);
        chk("clr_last",  64'(ao_last),  64'd0);
        chk("clr_ovf",   64'(ao_ovf),   64'd0);
        a_clr = 1'b0; a_valid = 1'b0;
        send_a(64'h01, 64'($urandom), 1'b1, W, -1, 0, -1);

        // Asynchronous reset mid-word, off the clock edge
        send_a(64'h01, 64'h01, 1'b1, 3, -1, 0, -1);
        #2;
        r = 1'b1;
        #1;
        chk("arst_valid", 64'(ao_valid), 64'd0);
        chk("arst_bit",   64'(ao_bit),   64'd0);
        chk("arst_last",  64'(ao_last),  64'd0);
        chk("arst_ovf",   64'(ao_ovf),   64'd0);
        #2;
        r = 1'b0;
        send_a(64'h02, 64'($urandom), 1'b1, W, -1, 0, -1);

        // Random words, modes, gaps and mid-word mode flips
        for (int n = 0; n < 10; n++) begin
            int fa;
            fa = int'($urandom_range(0, 7));
            if (fa == 0) fa = -1;
            send_a(64'($urandom), 64'($urandom), 1'($urandom), W,
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), fa);
        end

        // Narrow instance: back-to-back words through the counter wrap
        send_b(64'h3, 1'b1);
        send_b(64'h8, 1'b1);
        send_b(64'h0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            send_b(64'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_twos_comp_n.md
Name: serial_twos_comp_n

Overview:
- Parametrised, multi-lane, bit-serial two's complementer with word framing.
- Each lane receives words LSB-first, one bit per valid cycle.
- Each lane emits either the unchanged word or its two's-complement negation, chosen per word.
- Adds over the single-bit serial inverter: word framing with a last-bit marker, valid gaps, a per-word negate/pass mode, lanes, synchronous frame abort and an overflow flag for the most-negative input.

Parameters:
- WIDTH, 8, bits per word; legal range 2..64.
- LANES, 1, number of independent serial lanes sharing one framing counter.

Ports:
- t_clk  input  1  clock; all state updates on the rising edge.
- r  input  1  reset; asynchronous and active-high.
- i_valid  input  1  i_bit holds a valid bit in this cycle.
- i_bit  input  LANES  serial data bits, LSB of the word first; bit k belongs to lane k.
- i_neg  input  1  word mode, sampled only on the first bit of a word: 1 = negate, 0 = pass.
- i_clr  input  1  synchronous frame abort.
- o_valid  output  1  o_bit is valid in this cycle.
- o_bit  output  LANES  serial result bits.
- o_last  output  1  marks the MSB (final bit) of an output word.
- o_ovf  output  LANES  per lane, asserted with o_last when a negated word was 100..0.

Behaviour:
- Reset (r=1, asynchronous):
  - o_valid, o_bit, o_last and o_ovf go to 0.
  - Bit counter goes to 0, word mode to pass, every lane to COPY.
  - Reset takes effect mid-word; after release the next valid bit is bit 0 of a new word.
- Latency: exactly 1 cycle. Outputs are registered; o_valid(t+1) = i_valid(t) when i_clr(t)=0.
- Gaps: i_valid=0 holds the counter, mode and lane states. o_valid drops to 0 and o_bit holds its last value. There is no backpressure.
- Framing counter cnt:
  - Range 0..WIDTH-1, width clog2(WIDTH).
  - Increments on each i_valid; wraps from WIDTH-1 to 0.
  - o_last(t+1) = i_valid(t) and cnt==WIDTH-1.
- Mode: at cnt==0 with i_valid, i_neg is latched for the whole word. A change in i_neg mid-word is ignored.
- Per-lane state machine, two states:
  - COPY: out = in. Moves to INVERT after a 1 is passed, provided the word mode is negate.
  - INVERT: out = ~in. Stays until the end of the word.
  - Every lane is forced to COPY at word start (cnt==0), before bit 0 is processed.
- Mode effect: in pass mode the lane stays in COPY, so out = in for every bit.
- Overflow:
  - Condition: negate mode, cnt==WIDTH-1, the lane is still in COPY, and in==1.
  - Action: o_ovf[k]=1 for one cycle alongside o_last, and the output word equals the input word.
  - Otherwise o_ovf[k]=0.
- Zero word in negate mode: output is 0, o_ovf=0.
- i_clr=1:
  - Next edge: cnt goes to 0, all lanes go to COPY, o_valid/o_last/o_ovf go to 0.
  - The i_valid bit in that cycle is discarded.
  - i_clr has priority over i_valid.
  - r has priority over everything.
- Lanes share cnt and mode, but COPY/INVERT and o_ovf are independent per lane.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package serial_pkg:
  - Lane state type {COPY, INVERT}.
  - Function for clog2.
  - Constant MODE_PASS=0 / MODE_NEG=1.
- One natural sub-module, serial_tc_lane: per-lane state flop, output bit mux and overflow detect. Instantiated LANES times by a generate loop.
- Top level holds the counter, mode latch, o_valid and o_last.

Test Plan (WIDTH=8, LANES=2 unless noted):
- Negate lane0=0x05, lane1=0x01, i_neg=1, 8 consecutive valids:
  - Outputs from cycle 2: lane0 0xFB (bits 1,1,0,1,1,1,1,1 in order), lane1 0xFF.
  - o_last high on the 8th output cycle only; o_ovf=00.
- Most-negative case: lane0=0x80, lane1=0x00, negate:
  - Outputs 0x80 and 0x00.
  - o_ovf=01 (lane0 only), asserted in the same cycle as o_last.
- Pass mode with mid-word i_neg toggle: i_neg=0 at bit 0, then i_neg=1 from bit 3, input 0x5A:
  - Output is 0x5A; o_ovf=0.
- Valid gaps: 0x0C negate, with i_valid low for 3 cycles between bits 2 and 3:
  - Output 0xF4.
  - o_valid tracks i_valid delayed by 1; cnt holds during the gap.
- Aborts: assert i_clr after 4 bits, then send 0x01 negate:
  - Output is 0xFF, with o_last on its 8th bit.
  - Repeat with r pulsed asynchronously (not aligned to t_clk) mid-word: all outputs go to 0 immediately, and the next word 0x02 negate gives 0xFE.
- WIDTH=4, LANES=1, back-to-back words 0x3, 0x8, 0x0 with no gap, all negate:
  - Outputs 0xD, 0x8 (o_ovf=1), 0x0.
  - Counter wraps with no idle cycle.
